freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, meaning clk cycles per measurement window (1 s at 100 MHz); legal range 2..2^27-1.
REQ-002 Port clk  input  1  sole system clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port en  input  1  measurement enable; windows run only while high.
REQ-005 Port sig_in  input  1  asynchronous slow square wave under measurement, e.g. a divided clock.
REQ-006 Port bcd  output  16  latched edge count of the last completed window, 4 BCD digits, [3:0] units to [15:12] thousands.
REQ-007 Port ovf  output  1  latched: last completed window saw more than 9999 edges.
REQ-008 Port valid  output  1  one-cycle pulse when bcd/ovf update.

Function
REQ-009 sig_in SHALL pass a 2-flop synchronizer; a third flop holds the previous synchronized value; rise = sync2 & ~prev.
REQ-010 The accumulator SHALL increment on the clock edge after rise is high, so a sig_in rising edge is counted at the earliest 3 cycles after it is sampled.
REQ-011 FSM states: IDLE, MEASURE; reset enters IDLE.
REQ-012 In IDLE: gate counter = 0 and accumulator = 0; if en = 1, go to MEASURE on the next edge.
REQ-013 In MEASURE: gate counter counts 0..GATE_CYCLES-1 and each rise increments the accumulator.
REQ-014 At gate count GATE_CYCLES-1 the block SHALL do all of the following in one edge:
  - latch the accumulator into bcd, including any rise present in that cycle;
  - latch the overflow flag into ovf;
  - assert valid for exactly that following cycle;
  - clear the accumulator and overflow flag;
  - wrap the gate counter to 0 and stay in MEASURE.
REQ-015 The accumulator SHALL count in BCD, digit wrap 9->0 with carry to the next digit, never holding a non-BCD nibble.
REQ-016 If a rise arrives with the accumulator at 9999, the accumulator SHALL hold 9999 and the window overflow flag SHALL be set.
REQ-017 If en falls during MEASURE, the window SHALL be aborted: go to IDLE next edge, no valid, and bcd/ovf keep their previous values.
REQ-018 Synchronizer flops SHALL keep running in IDLE so prev is fresh; the first window after enable SHALL NOT count a level that was already high as an edge.
REQ-019 bcd and ovf SHALL change only on the edge that pulses valid, or on reset.

Reset
REQ-020 With rst high, on the next clk edge the block SHALL set:
  - state = IDLE;
  - bcd = 16'h0000, ovf = 0, valid = 0;
  - gate counter, accumulator and overflow flag = 0;
  - synchronizer and prev flops = 0.
REQ-021 rst mid-window SHALL discard the partial count, with no valid pulse.
REQ-022 rst SHALL take priority over en and over the window-end latch.

Structure
REQ-023 Constants BCD_DIGITS (4) and BCD_MAX (16'h9999), plus the state encoding, SHALL live in a shared package.
REQ-024 Sub-module bcd_digit: one decade counter 0-9 with inc, clr, carry-out and is_nine; instantiated four times as a cascade. Saturation detect = all four is_nine.
REQ-025 The gate counter width SHALL be derived from GATE_CYCLES via clog2.

Verification (bench with GATE_CYCLES = 20 unless noted)
REQ-026 Reset: apply rst for 2 cycles with sig_in toggling -> bcd = 0000, ovf = 0, valid never high.
REQ-027 Steady rate: en = 1, sig_in period 4 cycles (high 2 / low 2) -> from the second window on, each valid shows bcd = 0005, ovf = 0, with valid spaced exactly 20 cycles apart.
REQ-028 Window boundary: a single rise timed to reach the accumulator on gate count 19 -> that window reports 0001 and the next window reports 0000.
REQ-029 Overflow: GATE_CYCLES = 20000, sig_in toggling every cycle (10000 rises) -> bcd = 9999, ovf = 1. The next window at 1/4 rate reports 5000, ovf = 0.
REQ-030 Abort: drop en at gate count 10 -> no valid, bcd keeps its prior value. Re-enable with sig_in held high -> the first window reports 0000.
REQ-031 Reset mid-window at gate count 7 with 3 edges counted -> no valid pulse. Next full window at period 4 reports 0005.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants, state encoding and BCD helper for the frequency meter.
package freq_meter_pkg;

  // Four decade digits give a 0..9999 edge count per window.
  localparam int BCD_DIGITS = 4;
  localparam logic [4*BCD_DIGITS-1:0] BCD_MAX = 16'h9999;

  // Window control states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // Next value of one decade digit: hold, or step with 9 -> 0 wrap.
  // Anything at or above 9 wraps, so a digit can never leave 0..9.
  function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic inc);
    if (!inc) begin
      return q;
    end else if (q >= 4'd9) begin
      return 4'd0;
    end else begin
      return q + 4'd1;
    end
  endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One decade counter (0-9) with clear, increment, carry-out and nine-detect.
module freq_meter_bcd_digit
  import freq_meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry,
  output logic       is_nine
);

  assign is_nine = (q == 4'd9);
  // Carry ripples to the next digit on the same edge this digit wraps.
  assign carry   = inc & is_nine;

  // Digit register: clear dominates increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 4'd0;
    end else begin
      q <= bcd_step(q, inc);
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over GATE_CYCLES clocks
// and reports the count as 4 BCD digits with a saturation/overflow flag.
//
// Output handshake: valid is a single-cycle pulse with no back-pressure.
// bcd and ovf are registered and change only on the edge that raises valid
// (or on reset), so they may be sampled at the pulse or any time after.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sig_in,
  output logic [4*BCD_DIGITS-1:0]   bcd,
  output logic                      ovf,
  output logic                      valid
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t state;
  state_t state_nxt;

  logic [GW-1:0] gate;

  logic sync1;
  logic sync2;
  logic prev;
  logic rise;

  logic counting;
  logic win_end;
  logic abort_win;
  logic acc_clr;

  logic [4*BCD_DIGITS-1:0] acc;
  logic [4*BCD_DIGITS-1:0] acc_nxt;
  logic [BCD_DIGITS-1:0]   dig_inc;
  logic [BCD_DIGITS-1:0]   dig_carry;
  logic [BCD_DIGITS-1:0]   dig_nine;
  logic                    sat;
  logic                    inc_req;
  logic                    inc0;
  logic                    ovf_flag;

  // Synchronizer plus previous-value flop; runs in every state so the
  // edge detector never sees a stale level when a window starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enable starts measuring, dropping enable aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en)  state_nxt = ST_MEASURE;
      ST_MEASURE: if (!en) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Window control decoded from state, enable and gate position.
  always_comb begin
    counting  = 1'b0;
    win_end   = 1'b0;
    abort_win = 1'b0;
    acc_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_clr = 1'b1;
      end
      ST_MEASURE: begin
        counting  = en;
        abort_win = ~en;
        win_end   = en && (gate == GATE_LAST);
        acc_clr   = abort_win | win_end;
      end
      default: begin
        acc_clr = 1'b1;
      end
    endcase
  end

  // Gate counter walks 0..GATE_CYCLES-1 while measuring, else parks at 0.
  always_ff @(posedge clk) begin
    if (rst || !counting || win_end) begin
      gate <= '0;
    end else begin
      gate <= gate + GW'(1);
    end
  end

  // Saturation: once every digit reads 9 further rises only flag overflow.
  assign sat     = &dig_nine;
  assign inc_req = counting & rise;
  assign inc0    = inc_req & ~sat;
  assign dig_inc = {dig_carry[BCD_DIGITS-2:0], inc0};

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    freq_meter_bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc_clr),
      .inc     (dig_inc[i]),
      .q       (acc[i*4 +: 4]),
      .carry   (dig_carry[i]),
      .is_nine (dig_nine[i])
    );
  end

  // Accumulator value including this cycle's rise; latched at window end
  // because the digits themselves are cleared on that same edge.
  always_comb begin
    acc_nxt = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      acc_nxt[i*4 +: 4] = bcd_step(acc[i*4 +: 4], dig_inc[i]);
    end
  end

  // Window overflow flag: set by a rise that arrives while saturated.
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      ovf_flag <= 1'b0;
    end else if (inc_req && sat) begin
      ovf_flag <= 1'b1;
    end
  end

  // Result registers: update only at a completed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd   <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= win_end;
      if (win_end) begin
        bcd <= acc_nxt;
        ovf <= ovf_flag | (inc_req & sat);
      end
    end
  end

  // The top digit never wraps because increments stop at saturation.
  a_no_top_carry: assert property (@(posedge clk) disable iff (rst)
    !dig_carry[BCD_DIGITS-1]);

  // Saturation detect agrees with the accumulator value.
  a_sat_matches: assert property (@(posedge clk) disable iff (rst)
    sat == (acc == BCD_MAX));

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (short and long gate), a per-cycle
// reference model pushing expected reports into queues, and a monitor that
// pops and compares whenever a DUT pulses valid.
module tb_freq_meter;

  localparam int GC_S = 20;
  localparam int GC_B = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v;
  logic [1:0]       en_v;
  logic [1:0]       sig_v;
  logic [1:0][15:0] bcd_v;
  logic [1:0]       ovf_v;
  logic [1:0]       valid_v;

  freq_meter #(.GATE_CYCLES(GC_S)) dut_s (
    .clk    (clk),
    .rst    (rst_v[0]),
    .en     (en_v[0]),
    .sig_in (sig_v[0]),
    .bcd    (bcd_v[0]),
    .ovf    (ovf_v[0]),
    .valid  (valid_v[0])
  );

  freq_meter #(.GATE_CYCLES(GC_B)) dut_b (
    .clk    (clk),
    .rst    (rst_v[1]),
    .en     (en_v[1]),
    .sig_in (sig_v[1]),
    .bcd    (bcd_v[1]),
    .ovf    (ovf_v[1]),
    .valid  (valid_v[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected reports: {cycle[31:0], ovf, bcd[15:0]}
  logic [48:0] exp_q0[$];
  logic [48:0] exp_q1[$];

  // Reference model state (integer count, window position, sample history)
  bit          run[2];
  int          pos[2];
  int          cnt[2];
  logic [2:0]  hist[2];
  logic [15:0] mbcd[2];
  logic        movf[2];
  logic        mvalid[2];
  bit          chk_on[2];

  // Signal generator settings
  int   g_mode[2] = '{1, 1};
  int   g_p[2]    = '{2, 2};
  int   g_h[2]    = '{1, 1};
  int   g_ph[2]   = '{0, 0};
  logic g_lvl[2]  = '{1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    logic [15:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void push_exp(input int d, input logic [48:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [48:0] pop_exp(input int d);
    return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  // Model of one clock edge: a rise seen in the synchronized stream in a
  // measuring cycle adds one; every GC cycles the window result is issued.
  task automatic model_edge(input int d);
    int          gc;
    logic        rise_now;
    logic        ov;
    logic [15:0] b;
    gc = (d == 0) ? GC_S : GC_B;
    mvalid[d] = 1'b0;
    if (rst_v[d]) begin
      run[d]    = 1'b0;
      pos[d]    = 0;
      cnt[d]    = 0;
      hist[d]   = 3'b000;
      mbcd[d]   = 16'h0000;
      movf[d]   = 1'b0;
      chk_on[d] = 1'b1;
    end else begin
      // hist[1] = level two edges back, hist[2] = three edges back
      rise_now = hist[d][1] & ~hist[d][2];
      if (!run[d]) begin
        if (en_v[d]) begin
          run[d] = 1'b1;
          pos[d] = 0;
          cnt[d] = 0;
        end
      end else if (!en_v[d]) begin
        run[d] = 1'b0;
      end else begin
        if (rise_now) cnt[d]++;
        if (pos[d] == gc - 1) begin
          ov = (cnt[d] > 9999);
          b  = to_bcd(ov ? 9999 : cnt[d]);
          push_exp(d, {32'(cyc), ov, b});
          mbcd[d]   = b;
          movf[d]   = ov;
          mvalid[d] = 1'b1;
          cnt[d]    = 0;
          pos[d]    = 0;
        end else begin
          pos[d]++;
        end
      end
      hist[d] = {hist[d][1:0], sig_v[d]};
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) model_edge(d);
    end
  end

  // Monitor: compares valid every cycle, pops an expected report on valid.
  task automatic monitor_dut(input int d);
    logic [48:0] e;
    chk($sformatf("valid[%0d]", d), 32'(valid_v[d]), 32'(mvalid[d]));
    if (valid_v[d] === 1'b1) begin
      if (q_size(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid[%0d]: got pulse at cycle %0d, expected none", d, cyc);
      end else begin
        e = pop_exp(d);
        chk($sformatf("report_bcd[%0d]", d), 32'(bcd_v[d]), 32'(e[15:0]));
        chk($sformatf("report_ovf[%0d]", d), 32'(ovf_v[d]), 32'(e[16]));
        chk($sformatf("report_cycle[%0d]", d), 32'(cyc), e[48:17]);
      end
    end
    chk($sformatf("bcd_held[%0d]", d), 32'(bcd_v[d]), 32'(mbcd[d]));
    chk($sformatf("ovf_held[%0d]", d), 32'(ovf_v[d]), 32'(movf[d]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (chk_on[d]) monitor_dut(d);
    end
  end

  // Signal generator: applies settings 1 time unit after the falling edge
  initial begin
    sig_v = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (g_mode[d] == 1) begin
          sig_v[d] = (g_ph[d] < g_h[d]);
          g_ph[d]  = (g_ph[d] + 1) % g_p[d];
        end else begin
          sig_v[d] = g_lvl[d];
        end
      end
    end
  end

  task automatic set_square(input int d, input int p, input int h);
    g_p[d]    = p;
    g_h[d]    = h;
    g_ph[d]   = 0;
    g_mode[d] = 1;
  endtask

  task automatic set_level(input int d, input logic l);
    g_lvl[d]  = l;
    g_mode[d] = 0;
  endtask

  task automatic wait_valid(input int d, input int bound, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < bound) begin
      @(negedge clk);
      if (valid_v[d] === 1'b1) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_valid[%0d]: no pulse within %0d cycles, expected one", d, bound);
    end
  endtask

  task automatic wait_pos(input int d, input int p, input int bound);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (n < bound && !hit) begin
      @(negedge clk);
      if (run[d] && pos[d] == p) hit = 1'b1;
      n++;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_pos[%0d]: gate %0d not reached within %0d cycles", d, p, bound);
    end
  endtask

  initial begin
    int t0, t1, t2, p;
    rst_v = 2'b11;
    en_v  = 2'b00;

    // Reset with sig_in toggling on both instances
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_bcd[%0d]", d), 32'(bcd_v[d]), 32'h0000);
      chk($sformatf("reset_ovf[%0d]", d), 32'(ovf_v[d]), 32'h0);
      chk($sformatf("reset_valid[%0d]", d), 32'(valid_v[d]), 32'h0);
    end
    rst_v = 2'b00;

    // Steady period-4 input: five rises per 20-cycle window
    set_square(0, 4, 2);
    en_v[0] = 1'b1;
    wait_valid(0, 60, t0);
    wait_valid(0, 60, t1);
    chk("steady_bcd", 32'(bcd_v[0]), 32'h0005);
    chk("steady_ovf", 32'(ovf_v[0]), 32'h0);
    wait_valid(0, 60, t2);
    chk("steady_bcd2", 32'(bcd_v[0]), 32'h0005);
    chk("steady_spacing", 32'(t2 - t1), 32'd20);

    // Single rise landing on the last gate cycle
    set_level(0, 1'b0);
    wait_valid(0, 60, t0);
    wait_valid(0, 60, t0);
    wait_pos(0, 17, 60);
    set_level(0, 1'b1);
    wait_valid(0, 60, t0);
    chk("boundary_bcd", 32'(bcd_v[0]), 32'h0001);
    wait_valid(0, 60, t0);
    chk("boundary_next_bcd", 32'(bcd_v[0]), 32'h0000);

    // Abort at gate 10, then re-enable with the input already high
    wait_pos(0, 10, 60);
    en_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_bcd_kept", 32'(bcd_v[0]), 32'h0000);
    en_v[0] = 1'b1;
    wait_valid(0, 60, t0);
    chk("reenable_high_bcd", 32'(bcd_v[0]), 32'h0000);

    // Reset in the middle of a window
    set_square(0, 4, 2);
    wait_valid(0, 60, t0);
    wait_pos(0, 7, 60);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    wait_valid(0, 60, t0);
    wait_valid(0, 60, t0);
    chk("after_reset_bcd", 32'(bcd_v[0]), 32'h0005);

    // Randomized segments checked by the model
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_level(0, 1'($urandom_range(0, 1)));
      end else begin
        p = $urandom_range(2, 10);
        set_square(0, p, $urandom_range(1, p - 1));
      end
      en_v[0] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
      end
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end

    // Full-rate input carries into the tens digit
    en_v[0] = 1'b1;
    set_square(0, 2, 1);
    wait_valid(0, 60, t0);
    wait_valid(0, 60, t0);
    chk("toggle_bcd", 32'(bcd_v[0]), 32'h0010);

    // Long gate: 10000 rises saturate, then a quarter-rate window
    en_v[1] = 1'b1;
    wait_valid(1, GC_B + 100, t0);
    chk("overflow_bcd", 32'(bcd_v[1]), 32'h9999);
    chk("overflow_ovf", 32'(ovf_v[1]), 32'h1);
    en_v[1] = 1'b0;
    set_square(1, 4, 2);
    repeat (10) @(negedge clk);
    en_v[1] = 1'b1;
    wait_valid(1, GC_B + 100, t0);
    chk("quarter_bcd", 32'(bcd_v[1]), 32'h5000);
    chk("quarter_ovf", 32'(ovf_v[1]), 32'h0);
    en_v = 2'b00;

    repeat (3) @(negedge clk);
    chk("pending_reports_s", 32'(exp_q0.size()), 32'd0);
    chk("pending_reports_b", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
